request_queue: RTL and testbench
================================

# request_queue

Buffers memory requests emitted by the trace parser and presents them, oldest first, to the DRAM command scheduler. It latches every strobed non-NOP op into a circular FIFO, tracks how many clocks each entry has waited, and exposes a valid/ready pop interface. It also reports occupancy, back-pressure and dropped requests. It sits between the parser and the scheduler in the memory-controller simulation.

## Interface
- QUEUE_DEPTH, 16, number of entries; power of two, at least 2
- AGE_WIDTH, 8, width of the per-entry wait counter
- clk  in  1  clock, rising-edge
- rst_n  in  1  reset, asynchronous, active-low
- op_ready_s  in  1  parser strobe; opcode/address valid this cycle
- opcode  in  parsed_op_t  parsed operation (global_defs)
- address  in  ADDRESS_WIDTH  parsed address
- queue_full  out  1  occupancy == QUEUE_DEPTH
- req_valid  out  1  head entry present
- req_op  out  parsed_op_t  head opcode
- req_address  out  ADDRESS_WIDTH  head address
- req_age  out  AGE_WIDTH  clocks head entry has waited
- req_ready  in  1  scheduler accepts head this cycle
- occupancy  out  $clog2(QUEUE_DEPTH+1)  entries held
- drop_count  out  32  strobes lost because queue was full

## Operation
- Storage: QUEUE_DEPTH entries of {op, address, age}, head and tail pointers of $clog2(QUEUE_DEPTH) bits, separate occupancy counter.
- Pointers wrap modulo QUEUE_DEPTH. Empty/full are derived from occupancy, never from pointer equality.
- Push condition: op_ready_s && opcode != NOP && (!queue_full || pop). Write at tail, set age 0, tail+1.
- A strobe with opcode == NOP is ignored, is not counted and has no effect.
- Pop condition: req_valid && req_ready. Head+1. req_ready while empty is ignored.
- Simultaneous push and pop: both happen and occupancy is unchanged.
  - When full, the pop frees the slot for the push in the same edge, so nothing is dropped.
  - When empty, the push is taken and the pop is a no-op because req_valid=0. No bypass.
- Drop: op_ready_s && opcode != NOP && queue_full && !pop.
  - drop_count increments by 1, saturating at 32'hFFFF_FFFF.
  - Queue contents are unchanged.
- Aging: every clock, each occupied entry other than the one being written increments its age, saturating at all-ones. An entry popped this cycle is simply released.
- Outputs are show-ahead, driven combinationally from registered head state.
  - req_valid = occupancy != 0.
  - req_op, req_address and req_age come from the head entry.
  - When empty: req_op = NOP, req_address = 0, req_age = 0.
- queue_full is asserted when occupancy == QUEUE_DEPTH; it is a function of registered state only.

## Timing
- Reset (rst_n low, asynchronous):
  - Pointers, occupancy, drop_count and all ages clear to 0, and all entries are invalid.
  - Outputs: queue_full=0, req_valid=0, req_op=NOP, req_address=0, req_age=0, occupancy=0, drop_count=0.
  - Reset asserted mid-operation discards all queued entries immediately; no pops complete after assertion.
  - Deassertion is taken on the next rising edge.
- Push latency: a strobe sampled at edge N makes req_valid/req_op/req_address visible after edge N (1 cycle), with req_age = 0.
- Age: req_age increments by 1 per clock while the entry stays at head and unpopped.
- Pop: the handshake completes at the edge where req_valid && req_ready. The next entry, if any, appears after that edge, so back-to-back pops sustain 1 per clock.
- Occupancy and queue_full update on the same edge as the push/pop that changes them.
- op_ready_s is a single-cycle strobe. Each cycle it is high is treated as a distinct request.

## Test plan
- Reset then single push (op=READ, address=0x1A2B3C) with req_ready=0 for 5 clocks:
  - req_valid=1 one cycle after the strobe.
  - req_address=0x1A2B3C.
  - req_age reads 0,1,2,3,4.
  - occupancy=1.
- 16 pushes with req_ready=0, then a 17th strobe:
  - queue_full=1 after the 16th.
  - The 17th is dropped and drop_count=1.
  - Draining yields the 16 addresses in order.
- Full queue with a strobe and req_ready=1 in the same cycle:
  - No drop; occupancy stays 16.
  - The new entry is last out.
- Continuous push plus pop for 40 cycles, to exercise pointer wrap:
  - Output order matches input order.
  - occupancy stays 1.
  - No drops.
- NOP strobe, and req_ready on an empty queue:
  - occupancy, drop_count and pointers unchanged.
  - req_op=NOP.
- Assert rst_n low mid-stream with 7 entries held, between clock edges:
  - All outputs return to reset values immediately.
  - Subsequent pushes start from an empty queue.

Source files
------------

// File: rtl/request_queue.sv
// Circular request FIFO between the trace parser and the DRAM command scheduler:
// show-ahead head entry with per-entry wait ages, occupancy and drop reporting.
package global_defs;
  localparam int ADDRESS_WIDTH = 32;
  typedef enum logic [1:0] {
    NOP     = 2'd0,
    READ    = 2'd1,
    WRITE   = 2'd2,
    REFRESH = 2'd3
  } parsed_op_t;
endpackage

module request_queue
  import global_defs::*;
#(
  parameter int QUEUE_DEPTH = 16,
  parameter int AGE_WIDTH   = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             op_ready_s,
  input  parsed_op_t                       opcode,
  input  logic [ADDRESS_WIDTH-1:0]         address,
  output logic                             queue_full,
  output logic                             req_valid,
  output parsed_op_t                       req_op,
  output logic [ADDRESS_WIDTH-1:0]         req_address,
  output logic [AGE_WIDTH-1:0]             req_age,
  input  logic                             req_ready,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0] occupancy,
  output logic [31:0]                      drop_count
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int OCC_W = $clog2(QUEUE_DEPTH + 1);
  localparam logic [OCC_W-1:0]     OCC_FULL = OCC_W'(QUEUE_DEPTH);
  localparam logic [AGE_WIDTH-1:0] AGE_MAX  = {AGE_WIDTH{1'b1}};
  localparam logic [31:0]          DROP_MAX = 32'hFFFF_FFFF;

  parsed_op_t                 op_q   [QUEUE_DEPTH];
  parsed_op_t                 op_d   [QUEUE_DEPTH];
  logic [ADDRESS_WIDTH-1:0]   addr_q [QUEUE_DEPTH];
  logic [ADDRESS_WIDTH-1:0]   addr_d [QUEUE_DEPTH];
  logic [AGE_WIDTH-1:0]       age_q  [QUEUE_DEPTH];
  logic [AGE_WIDTH-1:0]       age_d  [QUEUE_DEPTH];
  logic [PTR_W-1:0]           offs_s [QUEUE_DEPTH];
  logic [PTR_W-1:0]           head_q, head_d;
  logic [PTR_W-1:0]           tail_q, tail_d;
  logic [OCC_W-1:0]           occ_q, occ_d;
  logic [31:0]                drop_q, drop_d;

  logic valid_s;
  logic full_s;
  logic strobe_s;
  logic pop_s;
  logic push_s;
  logic drop_s;

  function automatic logic [AGE_WIDTH-1:0] age_inc(input logic [AGE_WIDTH-1:0] a);
    if (a == AGE_MAX) begin
      return a;
    end else begin
      return a + AGE_WIDTH'(1);
    end
  endfunction

  // Handshake decode from registered occupancy; a full queue accepts a push only alongside a pop.
  always_comb begin
    valid_s  = (occ_q != OCC_W'(0));
    full_s   = (occ_q == OCC_FULL);
    strobe_s = op_ready_s && (opcode != NOP);
    pop_s    = valid_s && req_ready;
    push_s   = strobe_s && (!full_s || pop_s);
    drop_s   = strobe_s && full_s && !pop_s;
  end

  // Show-ahead outputs driven from the registered head entry.
  always_comb begin
    queue_full  = full_s;
    req_valid   = valid_s;
    occupancy   = occ_q;
    drop_count  = drop_q;
    req_op      = NOP;
    req_address = '0;
    req_age     = '0;
    if (valid_s) begin
      req_op      = op_q[head_q];
      req_address = addr_q[head_q];
      req_age     = age_q[head_q];
    end else begin
      req_op      = NOP;
      req_address = '0;
      req_age     = '0;
    end
  end

  // Pointer, occupancy and drop counter next state.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    drop_d = drop_q;
    if (pop_s) begin
      head_d = head_q + PTR_W'(1);
    end else begin
      head_d = head_q;
    end
    if (push_s) begin
      tail_d = tail_q + PTR_W'(1);
    end else begin
      tail_d = tail_q;
    end
    case ({push_s, pop_s})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
    if (drop_s && (drop_q != DROP_MAX)) begin
      drop_d = drop_q + 32'd1;
    end else begin
      drop_d = drop_q;
    end
  end

  // Entry storage: write at tail, otherwise age every slot within head..head+occupancy-1.
  always_comb begin
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      offs_s[i] = PTR_W'(i) - head_q;
      op_d[i]   = op_q[i];
      addr_d[i] = addr_q[i];
      age_d[i]  = age_q[i];
      if (push_s && (tail_q == PTR_W'(i))) begin
        op_d[i]   = opcode;
        addr_d[i] = address;
        age_d[i]  = '0;
      end else if ({1'b0, offs_s[i]} < occ_q) begin
        age_d[i]  = age_inc(age_q[i]);
      end else begin
        age_d[i]  = age_q[i];
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      drop_q <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        op_q[i]   <= NOP;
        addr_q[i] <= '0;
        age_q[i]  <= '0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      drop_q <= drop_d;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        op_q[i]   <= op_d[i];
        addr_q[i] <= addr_d[i];
        age_q[i]  <= age_d[i];
      end
    end
  end

endmodule

// File: tb/tb_request_queue.sv
// Directed bench for request_queue: a queue-based reference model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_request_queue;
  import global_defs::*;

  localparam int QD      = 16;
  localparam int AW      = 8;
  localparam int AGE_SAT = (1 << AW) - 1;

  logic                     clk;
  logic                     rst_n;
  logic                     op_ready_s;
  parsed_op_t               opcode;
  logic [ADDRESS_WIDTH-1:0] address;
  logic                     queue_full;
  logic                     req_valid;
  parsed_op_t               req_op;
  logic [ADDRESS_WIDTH-1:0] req_address;
  logic [AW-1:0]            req_age;
  logic                     req_ready;
  logic [$clog2(QD+1)-1:0]  occupancy;
  logic [31:0]              drop_count;

  int checks = 0;
  int errors = 0;

  parsed_op_t  mq_op[$];
  logic [31:0] mq_addr[$];
  int          mq_age[$];
  logic [31:0] m_drop = 32'd0;

  request_queue #(.QUEUE_DEPTH(QD), .AGE_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .op_ready_s(op_ready_s), .opcode(opcode),
    .address(address), .queue_full(queue_full), .req_valid(req_valid),
    .req_op(req_op), .req_address(req_address), .req_age(req_age),
    .req_ready(req_ready), .occupancy(occupancy), .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq_op.delete();
    mq_addr.delete();
    mq_age.delete();
    m_drop = 32'd0;
  endtask

  // Reference behaviour for one clock edge: age, release head, then accept or drop.
  task automatic model_step(input logic s, input parsed_op_t op, input logic [31:0] a, input logic rdy);
    int  n;
    bit  pop;
    bit  full;
    n    = mq_op.size();
    pop  = (n > 0) && rdy;
    full = (n == QD);
    foreach (mq_age[k]) if (mq_age[k] < AGE_SAT) mq_age[k]++;
    if (pop) begin
      void'(mq_op.pop_front());
      void'(mq_addr.pop_front());
      void'(mq_age.pop_front());
    end
    if (s && op != NOP) begin
      if (!full || pop) begin
        mq_op.push_back(op);
        mq_addr.push_back(a);
        mq_age.push_back(0);
      end else if (m_drop != 32'hFFFF_FFFF) begin
        m_drop++;
      end
    end
  endtask

  task automatic drive(input logic s, input parsed_op_t op, input logic [31:0] a, input logic rdy);
    op_ready_s = s;
    opcode     = op;
    address    = a;
    req_ready  = rdy;
    @(posedge clk);
    if (rst_n) model_step(s, op, a, rdy);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_queue_full"}, 64'(queue_full), 64'd0);
    chk({tag, "_req_valid"}, 64'(req_valid), 64'd0);
    chk({tag, "_req_op"}, 64'(req_op), 64'(NOP));
    chk({tag, "_req_address"}, 64'(req_address), 64'd0);
    chk({tag, "_req_age"}, 64'(req_age), 64'd0);
    chk({tag, "_occupancy"}, 64'(occupancy), 64'd0);
    chk({tag, "_drop_count"}, 64'(drop_count), 64'd0);
  endtask

  // Every falling edge: DUT outputs against the model.
  always @(negedge clk) begin
    int n;
    n = mq_op.size();
    chk("m_req_valid", 64'(req_valid), 64'(n > 0));
    chk("m_req_op", 64'(req_op), (n > 0) ? 64'(mq_op[0]) : 64'(NOP));
    chk("m_req_address", 64'(req_address), (n > 0) ? 64'(mq_addr[0]) : 64'd0);
    chk("m_req_age", 64'(req_age), (n > 0) ? 64'(mq_age[0]) : 64'd0);
    chk("m_occupancy", 64'(occupancy), 64'(n));
    chk("m_queue_full", 64'(queue_full), 64'(n == QD));
    chk("m_drop_count", 64'(drop_count), 64'(m_drop));
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; op_ready_s = 1'b0; opcode = NOP; address = 32'd0; req_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("por");
    rst_n = 1'b1;

    // Single push, then watch it age at the head.
    drive(1'b1, READ, 32'h001A_2B3C, 1'b0);
    chk("single_valid", 64'(req_valid), 64'd1);
    chk("single_op", 64'(req_op), 64'(READ));
    chk("single_addr", 64'(req_address), 64'h1A2B3C);
    chk("single_age0", 64'(req_age), 64'd0);
    chk("single_occ", 64'(occupancy), 64'd1);
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, NOP, 32'd0, 1'b0);
      chk("single_age", 64'(req_age), 64'(i));
    end
    drive(1'b0, NOP, 32'd0, 1'b1);
    chk("single_drained", 64'(req_valid), 64'd0);

    // Fill, overflow by one, drain in order.
    for (int i = 0; i < QD; i++) drive(1'b1, (i % 2) ? WRITE : READ, 32'h100 + i, 1'b0);
    chk("fill_full", 64'(queue_full), 64'd1);
    chk("fill_occ", 64'(occupancy), 64'd16);
    drive(1'b1, WRITE, 32'h1FF, 1'b0);
    chk("overflow_drop", 64'(drop_count), 64'd1);
    chk("overflow_occ", 64'(occupancy), 64'd16);
    chk("overflow_age", 64'(req_age), 64'd16);
    for (int i = 0; i < QD; i++) begin
      chk("drain_addr", 64'(req_address), 64'(32'h100 + i));
      drive(1'b0, NOP, 32'd0, 1'b1);
    end
    chk("drain_empty", 64'(req_valid), 64'd0);

    // Full queue with push and pop on the same edge.
    for (int i = 0; i < QD; i++) drive(1'b1, READ, 32'h200 + i, 1'b0);
    drive(1'b1, WRITE, 32'h2FF, 1'b1);
    chk("fullpp_drop", 64'(drop_count), 64'd1);
    chk("fullpp_occ", 64'(occupancy), 64'd16);
    chk("fullpp_full", 64'(queue_full), 64'd1);
    for (int i = 1; i < QD; i++) begin
      chk("fullpp_order", 64'(req_address), 64'(32'h200 + i));
      drive(1'b0, NOP, 32'd0, 1'b1);
    end
    chk("fullpp_last_addr", 64'(req_address), 64'h2FF);
    chk("fullpp_last_op", 64'(req_op), 64'(WRITE));
    drive(1'b0, NOP, 32'd0, 1'b1);

    // Streaming push+pop across several pointer wraps.
    drive(1'b1, READ, 32'h300, 1'b0);
    for (int i = 0; i < 40; i++) begin
      chk("wrap_addr", 64'(req_address), 64'(32'h300 + i));
      chk("wrap_occ", 64'(occupancy), 64'd1);
      drive(1'b1, READ, 32'h301 + i, 1'b1);
    end
    chk("wrap_drop", 64'(drop_count), 64'd1);
    drive(1'b0, NOP, 32'd0, 1'b1);

    // NOP strobe and ready on an empty queue, then a real push.
    drive(1'b1, NOP, 32'hDEAD, 1'b1);
    chk("nop_occ", 64'(occupancy), 64'd0);
    chk("nop_op", 64'(req_op), 64'(NOP));
    chk("nop_drop", 64'(drop_count), 64'd1);
    drive(1'b1, WRITE, 32'h444, 1'b0);
    chk("after_nop_addr", 64'(req_address), 64'h444);
    chk("after_nop_occ", 64'(occupancy), 64'd1);
    // Age saturation on a long-waiting head.
    repeat (AGE_SAT + 5) drive(1'b0, NOP, 32'd0, 1'b0);
    chk("age_sat", 64'(req_age), 64'd255);
    drive(1'b0, NOP, 32'd0, 1'b1);

    // NOP strobe on a full queue is not a drop.
    for (int i = 0; i < QD; i++) drive(1'b1, READ, 32'h700 + i, 1'b0);
    drive(1'b1, NOP, 32'h7FF, 1'b0);
    chk("nop_full_drop", 64'(drop_count), 64'd1);
    chk("nop_full_occ", 64'(occupancy), 64'd16);
    repeat (QD) drive(1'b0, NOP, 32'd0, 1'b1);

    // Asynchronous reset between edges with 7 entries held.
    for (int i = 0; i < 7; i++) drive(1'b1, WRITE, 32'h400 + i, 1'b0);
    chk("pre_rst_occ", 64'(occupancy), 64'd7);
    op_ready_s = 1'b1; opcode = READ; address = 32'h4FF; req_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_values("midrst");
    @(posedge clk);
    #1;
    check_reset_values("midrst_hold");
    rst_n = 1'b1;
    drive(1'b1, READ, 32'h500, 1'b0);
    chk("post_rst_occ", 64'(occupancy), 64'd1);
    chk("post_rst_addr", 64'(req_address), 64'h500);
    chk("post_rst_age", 64'(req_age), 64'd0);
    drive(1'b0, NOP, 32'd0, 1'b0);
    chk("post_rst_age1", 64'(req_age), 64'd1);
    drive(1'b0, NOP, 32'd0, 1'b1);
    @(negedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
